// File: rtl/freq_pkg.sv
// Shared definitions for the frequency-scan controller and host-side conversion.
package freq_pkg;

  // Scan sequencer states
  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StSettle,
    StArm,
    StMeasure,
    StStore
  } state_e;

  localparam int unsigned DefCntW    = 32;
  localparam int unsigned DefTimeout = 50_000_000;
  // System clock frequency; host converts period P to Hz as ClkFreqHz / P
  localparam int unsigned ClkFreqHz  = 50_000_000;

endpackage

// File: rtl/freq_sync_edge.sv
// Two-flop synchronizers for the raw asynchronous signal pins.
module freq_sync_edge
  import freq_pkg::*;
#(
  parameter int unsigned NUM_CH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] sig,
  output logic [NUM_CH-1:0] sig_sync
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
    logic meta_q;
    logic sync_q;

    // Metastability filter for one input
    always_ff @(posedge clk) begin
      if (!reset) begin
        meta_q <= 1'b0;
        sync_q <= 1'b0;
      end else begin
        meta_q <= sig[g];
        sync_q <= meta_q;
      end
    end

    assign sig_sync[g] = sync_q;
  end

endmodule

// File: rtl/freq_scan_ctrl.sv
// Round-robin period measurement over NUM_CH asynchronous inputs sharing one counter.
module freq_scan_ctrl
  import freq_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CH_W    = 2,
  parameter int unsigned CNT_W   = DefCntW,
  parameter int unsigned TIMEOUT = DefTimeout,
  parameter int unsigned SETTLE  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [NUM_CH-1:0] sig,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [CNT_W-1:0]  rd_period,
  output logic              rd_valid,
  output logic              rd_timeout,
  output logic [CH_W-1:0]   cur_ch,
  output logic              busy,
  output logic              meas_done,
  output logic [CH_W-1:0]   done_ch
);

  state_e             state_q, state_d;
  logic [CH_W-1:0]    cur_ch_q, cur_ch_d;
  logic [CH_W-1:0]    last_ch_q, last_ch_d;
  logic [31:0]        timer_q, timer_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   meas_q, meas_d;
  logic               to_q, to_d;
  logic               sel_d1_q;
  logic               wr_en;

  logic [NUM_CH-1:0]  sig_sync;
  logic               sel;
  logic               edge_det;
  logic               found;
  logic [CH_W-1:0]    next_ch;
  int unsigned        srch_idx;

  logic [CNT_W-1:0]   period_q [NUM_CH];
  logic [NUM_CH-1:0]  valid_q;
  logic [NUM_CH-1:0]  timeout_q;

  freq_sync_edge #(
    .NUM_CH (NUM_CH)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .sig      (sig),
    .sig_sync (sig_sync)
  );

  // Mux after synchronization; edge only consumed in ARM/MEASURE, so SETTLE masks it
  assign sel      = sig_sync[cur_ch_q];
  assign edge_det = sel & ~sel_d1_q;

  // Next enabled channel after last_ch, wrapping, last_ch itself considered last
  always_comb begin
    found    = 1'b0;
    next_ch  = '0;
    srch_idx = 0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      srch_idx = (32'(last_ch_q) + i) % NUM_CH;
      if (!found && ch_mask[srch_idx]) begin
        found   = 1'b1;
        next_ch = CH_W'(srch_idx);
      end
    end
  end

  // Sequencer next-state, timer and period counter
  always_comb begin
    state_d   = state_q;
    cur_ch_d  = cur_ch_q;
    last_ch_d = last_ch_q;
    timer_d   = timer_q;
    cnt_d     = cnt_q;
    meas_d    = meas_q;
    to_d      = to_q;
    wr_en     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (en && (ch_mask != '0)) state_d = StSelect;
      end
      StSelect: begin
        if (found) begin
          cur_ch_d = next_ch;
          timer_d  = '0;
          to_d     = 1'b0;
          state_d  = StSettle;
        end else begin
          state_d = StIdle;
        end
      end
      StSettle: begin
        if (timer_q == 32'(SETTLE - 1)) begin
          timer_d = '0;
          state_d = StArm;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      StArm: begin
        timer_d = timer_q + 32'd1;
        if (edge_det) begin
          cnt_d   = CNT_W'(1);
          state_d = StMeasure;
        end else if (timer_q == 32'(TIMEOUT - 1)) begin
          to_d    = 1'b1;
          state_d = StStore;
        end
      end
      StMeasure: begin
        timer_d = timer_q + 32'd1;
        if (edge_det) begin
          meas_d  = cnt_q;
          state_d = StStore;
        end else begin
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          if (timer_q == 32'(TIMEOUT - 1)) begin
            to_d    = 1'b1;
            state_d = StStore;
          end
        end
      end
      StStore: begin
        wr_en     = 1'b1;
        last_ch_d = cur_ch_q;
        state_d   = en ? StSelect : StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Losing enable abandons the channel without writing anything
    if (!en && (state_q != StIdle)) begin
      state_d   = StIdle;
      wr_en     = 1'b0;
      last_ch_d = last_ch_q;
    end
  end

  // Sequencer state registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      cur_ch_q  <= '0;
      last_ch_q <= CH_W'(NUM_CH - 1);
      timer_q   <= '0;
      cnt_q     <= '0;
      meas_q    <= '0;
      to_q      <= 1'b0;
      sel_d1_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_ch_q  <= cur_ch_d;
      last_ch_q <= last_ch_d;
      timer_q   <= timer_d;
      cnt_q     <= cnt_d;
      meas_q    <= meas_d;
      to_q      <= to_d;
      sel_d1_q  <= sel;
    end
  end

  // Per-channel result store
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) period_q[i] <= '0;
      valid_q   <= '0;
      timeout_q <= '0;
    end else if (wr_en) begin
      period_q[cur_ch_q]  <= to_q ? '0 : meas_q;
      valid_q[cur_ch_q]   <= ~to_q;
      timeout_q[cur_ch_q] <= to_q;
    end
  end

  // Registered read port; same-cycle write is seen one cycle later
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_period  <= '0;
      rd_valid   <= 1'b0;
      rd_timeout <= 1'b0;
    end else begin
      rd_period  <= period_q[rd_ch];
      rd_valid   <= valid_q[rd_ch];
      rd_timeout <= timeout_q[rd_ch];
    end
  end

  assign cur_ch    = cur_ch_q;
  assign busy      = (state_q != StIdle);
  assign meas_done = wr_en;
  assign done_ch   = cur_ch_q;

endmodule

// File: tb/tb_freq_scan_ctrl.sv
// Scoreboard bench for freq_scan_ctrl: stimulus queues expected results, monitor checks them.
`timescale 1ns/1ps
module tb_freq_scan_ctrl;

  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned CH_W    = 2;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned TIMEOUT = 1000;
  localparam int unsigned SETTLE  = 2;

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [CNT_W-1:0] period;
    logic             valid;
    logic             timeout;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic [NUM_CH-1:0] ch_mask;
  wire  [NUM_CH-1:0] sig;
  wire  [CH_W-1:0]   rd_ch;
  logic [CNT_W-1:0]  rd_period;
  logic              rd_valid;
  logic              rd_timeout;
  logic [CH_W-1:0]   cur_ch;
  logic              busy;
  logic              meas_done;
  logic [CH_W-1:0]   done_ch;

  int unsigned per [NUM_CH];
  bit          lvl [NUM_CH];

  exp_t             exp_q[$];
  exp_t             mon_e;
  bit               mon_busy = 1'b0;
  logic [CH_W-1:0]  mon_ch = '0;
  logic [CH_W-1:0]  stim_ch;
  logic [CNT_W-1:0] m_period [NUM_CH];
  bit               m_valid  [NUM_CH];
  bit               m_to     [NUM_CH];
  int               checks = 0;
  int               failures = 0;
  int               n;

  assign rd_ch = mon_busy ? mon_ch : stim_ch;

  always #5 clk = ~clk;

  freq_scan_ctrl #(
    .NUM_CH  (NUM_CH),
    .CH_W    (CH_W),
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT),
    .SETTLE  (SETTLE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .ch_mask    (ch_mask),
    .sig        (sig),
    .rd_ch      (rd_ch),
    .rd_period  (rd_period),
    .rd_valid   (rd_valid),
    .rd_timeout (rd_timeout),
    .cur_ch     (cur_ch),
    .busy       (busy),
    .meas_done  (meas_done),
    .done_ch    (done_ch)
  );

  // Per-channel signal generators: per=0 holds lvl, else square wave of per cycles
  for (genvar g = 0; g < NUM_CH; g++) begin : g_sig
    logic        s = 1'b0;
    int unsigned p;
    assign sig[g] = s;
    initial begin
      forever begin
        p = per[g];
        if (p == 0) begin
          s = lvl[g];
          @(negedge clk);
        end else begin
          s = 1'b1;
          repeat (p / 2) @(negedge clk);
          s = 1'b0;
          repeat (p - p / 2) @(negedge clk);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push_exp(input int ch, input int unsigned p, input bit v, input bit t);
    exp_q.push_back('{ch: CH_W'(ch), period: CNT_W'(p), valid: v, timeout: t});
  endtask

  task automatic drain(input int max_cyc);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || mon_busy) && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (exp_q.size() != 0 || mon_busy) begin
      failures++;
      $display("FAIL drain: %0d results pending after %0d cycles, expected 0", exp_q.size(),
               max_cyc);
      exp_q.delete();
    end
  endtask

  task automatic rd_check(input int ch, input int unsigned p, input bit v, input bit t,
                          input string nm);
    @(negedge clk);
    stim_ch = CH_W'(ch);
    @(posedge clk);
    #1;
    check({nm, "_period"}, rd_period, p);
    check({nm, "_valid"}, rd_valid, v);
    check({nm, "_timeout"}, rd_timeout, t);
  endtask

  task automatic clear_model();
    for (int i = 0; i < NUM_CH; i++) begin
      m_period[i] = '0;
      m_valid[i]  = 1'b0;
      m_to[i]     = 1'b0;
    end
  endtask

  // Monitor: every meas_done pops one expectation, then reads back old and new value
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && meas_done === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_meas_done: got done_ch=%0d, expected no result", done_ch);
        end else begin
          mon_e    = exp_q.pop_front();
          mon_ch   = mon_e.ch;
          mon_busy = 1'b1;
          check("done_ch", done_ch, mon_e.ch);
          @(posedge clk);
          #1;
          check("old_period", rd_period, m_period[mon_e.ch]);
          check("old_valid", rd_valid, m_valid[mon_e.ch]);
          check("old_timeout", rd_timeout, m_to[mon_e.ch]);
          @(posedge clk);
          #1;
          check("new_period", rd_period, mon_e.period);
          check("new_valid", rd_valid, mon_e.valid);
          check("new_timeout", rd_timeout, mon_e.timeout);
          m_period[mon_e.ch] = mon_e.period;
          m_valid[mon_e.ch]  = mon_e.valid;
          m_to[mon_e.ch]     = mon_e.timeout;
          mon_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    #600us;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b0;
    en      = 1'b0;
    ch_mask = '0;
    stim_ch = '0;
    clear_model();
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_rd_period", rd_period, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_timeout", rd_timeout, 0);
    check("rst_meas_done", meas_done, 0);
    check("rst_cur_ch", cur_ch, 0);
    reset = 1'b1;

    // 1: single channel, period 100 then minimum period 2
    per[0]  = 100;
    ch_mask = 4'b0001;
    repeat (200) @(negedge clk);
    push_exp(0, 100, 1, 0);
    en = 1'b1;
    drain(1000);
    en = 1'b0;
    per[0] = 2;
    repeat (300) @(negedge clk);
    push_exp(0, 2, 1, 0);
    en = 1'b1;
    drain(1000);
    en = 1'b0;

    // 2: two channels alternate, starting after last_ch=0
    per[1]  = 50;
    per[3]  = 80;
    ch_mask = 4'b1010;
    repeat (200) @(negedge clk);
    push_exp(1, 50, 1, 0);
    push_exp(3, 80, 1, 0);
    push_exp(1, 50, 1, 0);
    push_exp(3, 80, 1, 0);
    en = 1'b1;
    drain(2000);
    en = 1'b0;
    repeat (5) @(negedge clk);
    rd_check(2, 0, 0, 0, "ch2_untouched");
    rd_check(0, 2, 1, 0, "ch0_unchanged");

    // 3: dead channel times out, latency measured from enable
    per[2]  = 0;
    lvl[2]  = 1'b0;
    ch_mask = 4'b0100;
    repeat (200) @(negedge clk);
    push_exp(2, 0, 0, 1);
    push_exp(2, 0, 0, 1);
    en = 1'b1;
    n  = 0;
    do begin
      @(negedge clk);
      n++;
    end while (meas_done !== 1'b1 && n < 3000);
    check("timeout_latency_in_1002_1006", (n >= 1002 && n <= 1006), 1);
    drain(3000);
    en = 1'b0;

    // 4: stuck-high ch0 after low ch2 must not fake an edge; ch1 period 64
    per[0]  = 0;
    lvl[0]  = 1'b1;
    per[1]  = 64;
    ch_mask = 4'b0011;
    repeat (200) @(negedge clk);
    push_exp(0, 0, 0, 1);
    push_exp(1, 64, 1, 0);
    en = 1'b1;
    drain(3000);
    en = 1'b0;

    // 5: drop enable mid-MEASURE, result kept, resume after last channel
    per[0]  = 100;
    ch_mask = 4'b0001;
    repeat (200) @(negedge clk);
    push_exp(0, 100, 1, 0);
    en = 1'b1;
    drain(1000);
    repeat (10) @(negedge clk);
    @(posedge sig[0]);
    repeat (20) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_meas_done", meas_done, 0);
    repeat (5) @(negedge clk);
    rd_check(0, 100, 1, 0, "ch0_after_abort");
    ch_mask = 4'b0011;
    push_exp(1, 64, 1, 0);
    en = 1'b1;
    drain(1000);
    en = 1'b0;

    // 6: one-clock reset during MEASURE, scan restarts at ch0
    ch_mask = 4'b0001;
    repeat (5) @(negedge clk);
    en = 1'b1;
    repeat (10) @(negedge clk);
    @(posedge sig[0]);
    repeat (20) @(negedge clk);
    reset   = 1'b0;
    ch_mask = 4'b0011;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rd_period", rd_period, 0);
    check("mid_rst_rd_valid", rd_valid, 0);
    check("mid_rst_rd_timeout", rd_timeout, 0);
    check("mid_rst_cur_ch", cur_ch, 0);
    clear_model();
    push_exp(0, 100, 1, 0);
    reset = 1'b1;
    drain(1000);
    en = 1'b0;
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
